// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions for the peripheral-port arbiter:
// arbiter state encoding and response codes.
package axil_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    WR_RESP = 3'd2,
    RD_ADDR = 3'd3,
    RD_RESP = 3'd4
  } arb_state_e;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

endpackage

// File: rtl/axil_rr_pick.sv
// Two-way round-robin selector: a lone requester wins, a tie goes to the
// master that did not own the slave last.
module axil_rr_pick (
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic       winner,
  output logic       valid
);

  always_comb begin
    valid  = |req;
    winner = (req == 2'b11) ? ~last_owner : req[1];
  end

endmodule

// File: rtl/axil_arbiter_2to1.sv
// Two-master to one-slave AXI4-Lite arbiter. One whole transaction is granted
// at a time; the owner's channels are forwarded combinationally to the slave.
//
// state   | meaning
// IDLE    | no owner, arbitrating between pending requests
// WR      | owner's AW and/or W still pending on the slave
// WR_RESP | waiting for the B handshake
// RD_ADDR | forwarding AR until accepted
// RD_RESP | waiting for the R handshake
module axil_arbiter_2to1
  import axil_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic                aclk,
  input  logic                aresetn,

  input  logic [ADDR_W-1:0]   m0_awaddr,
  input  logic [2:0]          m0_awprot,
  input  logic                m0_awvalid,
  output logic                m0_awready,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  input  logic                m0_wvalid,
  output logic                m0_wready,
  output logic [1:0]          m0_bresp,
  output logic                m0_bvalid,
  input  logic                m0_bready,
  input  logic [ADDR_W-1:0]   m0_araddr,
  input  logic [2:0]          m0_arprot,
  input  logic                m0_arvalid,
  output logic                m0_arready,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic [1:0]          m0_rresp,
  output logic                m0_rvalid,
  input  logic                m0_rready,

  input  logic [ADDR_W-1:0]   m1_awaddr,
  input  logic [2:0]          m1_awprot,
  input  logic                m1_awvalid,
  output logic                m1_awready,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  input  logic                m1_wvalid,
  output logic                m1_wready,
  output logic [1:0]          m1_bresp,
  output logic                m1_bvalid,
  input  logic                m1_bready,
  input  logic [ADDR_W-1:0]   m1_araddr,
  input  logic [2:0]          m1_arprot,
  input  logic                m1_arvalid,
  output logic                m1_arready,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic [1:0]          m1_rresp,
  output logic                m1_rvalid,
  input  logic                m1_rready,

  output logic [ADDR_W-1:0]   s_awaddr,
  output logic [2:0]          s_awprot,
  output logic                s_awvalid,
  input  logic                s_awready,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  output logic                s_wvalid,
  input  logic                s_wready,
  input  logic [1:0]          s_bresp,
  input  logic                s_bvalid,
  output logic                s_bready,
  output logic [ADDR_W-1:0]   s_araddr,
  output logic [2:0]          s_arprot,
  output logic                s_arvalid,
  input  logic                s_arready,
  input  logic [DATA_W-1:0]   s_rdata,
  input  logic [1:0]          s_rresp,
  input  logic                s_rvalid,
  output logic                s_rready,

  output logic [1:0]          grant,
  output logic                busy
);

  arb_state_e state;
  logic       last_owner;
  logic       aw_done;
  logic       w_done;
  logic       pick_winner;
  logic       pick_valid;
  logic       own1;
  logic       fwd_wr, fwd_b, fwd_ar, fwd_r;
  logic       aw_fin, w_fin;

  axil_rr_pick u_pick (
    .req        ({m1_awvalid | m1_arvalid, m0_awvalid | m0_arvalid}),
    .last_owner (last_owner),
    .winner     (pick_winner),
    .valid      (pick_valid)
  );

  always_comb begin
    own1   = grant[1];
    fwd_wr = (state == WR);
    fwd_b  = (state == WR_RESP);
    fwd_ar = (state == RD_ADDR);
    fwd_r  = (state == RD_RESP);
  end

  // Master-to-slave direction; valids are gated by state and sticky flags.
  always_comb begin
    s_awaddr  = own1 ? m1_awaddr : m0_awaddr;
    s_awprot  = own1 ? m1_awprot : m0_awprot;
    s_wdata   = own1 ? m1_wdata  : m0_wdata;
    s_wstrb   = own1 ? m1_wstrb  : m0_wstrb;
    s_araddr  = own1 ? m1_araddr : m0_araddr;
    s_arprot  = own1 ? m1_arprot : m0_arprot;
    s_awvalid = fwd_wr & ~aw_done & (own1 ? m1_awvalid : m0_awvalid);
    s_wvalid  = fwd_wr & ~w_done  & (own1 ? m1_wvalid  : m0_wvalid);
    s_bready  = fwd_b  & (own1 ? m1_bready  : m0_bready);
    s_arvalid = fwd_ar & (own1 ? m1_arvalid : m0_arvalid);
    s_rready  = fwd_r  & (own1 ? m1_rready  : m0_rready);
  end

  // Slave-to-master direction; the non-owner sees all zeros.
  always_comb begin
    m0_awready = fwd_wr & grant[0] & ~aw_done & s_awready;
    m0_wready  = fwd_wr & grant[0] & ~w_done  & s_wready;
    m0_bvalid  = fwd_b  & grant[0] & s_bvalid;
    m0_bresp   = (fwd_b & grant[0]) ? s_bresp : OKAY;
    m0_arready = fwd_ar & grant[0] & s_arready;
    m0_rvalid  = fwd_r  & grant[0] & s_rvalid;
    m0_rdata   = (fwd_r & grant[0]) ? s_rdata : '0;
    m0_rresp   = (fwd_r & grant[0]) ? s_rresp : OKAY;

    m1_awready = fwd_wr & grant[1] & ~aw_done & s_awready;
    m1_wready  = fwd_wr & grant[1] & ~w_done  & s_wready;
    m1_bvalid  = fwd_b  & grant[1] & s_bvalid;
    m1_bresp   = (fwd_b & grant[1]) ? s_bresp : OKAY;
    m1_arready = fwd_ar & grant[1] & s_arready;
    m1_rvalid  = fwd_r  & grant[1] & s_rvalid;
    m1_rdata   = (fwd_r & grant[1]) ? s_rdata : '0;
    m1_rresp   = (fwd_r & grant[1]) ? s_rresp : OKAY;
  end

  always_comb begin
    aw_fin = aw_done | (s_awvalid & s_awready);
    w_fin  = w_done  | (s_wvalid  & s_wready);
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state      <= IDLE;
      grant      <= 2'b00;
      busy       <= 1'b0;
      last_owner <= 1'b1;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            grant      <= pick_winner ? 2'b10 : 2'b01;
            last_owner <= pick_winner;
            busy       <= 1'b1;
            state      <= (pick_winner ? m1_awvalid : m0_awvalid) ? WR : RD_ADDR;
          end
        end
        WR: begin
          if (aw_fin && w_fin) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            state   <= WR_RESP;
          end else begin
            aw_done <= aw_fin;
            w_done  <= w_fin;
          end
        end
        WR_RESP: begin
          if (s_bvalid && s_bready) begin
            state <= IDLE;
            grant <= 2'b00;
            busy  <= 1'b0;
          end
        end
        RD_ADDR: begin
          if (s_arvalid && s_arready) state <= RD_RESP;
        end
        RD_RESP: begin
          if (s_rvalid && s_rready) begin
            state <= IDLE;
            grant <= 2'b00;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          grant <= 2'b00;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axil_arbiter_2to1.sv
// Directed bench for axil_arbiter_2to1: a table of single transactions plus
// hand-written sequences for arbitration order, split AW/W and mid-flight reset.
module tb_axil_arbiter_2to1;
  import axil_pkg::*;

  logic        aclk = 1'b0;
  logic        aresetn;

  logic [11:0] m0_awaddr, m1_awaddr, s_awaddr;
  logic [2:0]  m0_awprot, m1_awprot, s_awprot;
  logic        m0_awvalid, m1_awvalid, s_awvalid;
  logic        m0_awready, m1_awready, s_awready;
  logic [31:0] m0_wdata, m1_wdata, s_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb, s_wstrb;
  logic        m0_wvalid, m1_wvalid, s_wvalid;
  logic        m0_wready, m1_wready, s_wready;
  logic [1:0]  m0_bresp, m1_bresp, s_bresp;
  logic        m0_bvalid, m1_bvalid, s_bvalid;
  logic        m0_bready, m1_bready, s_bready;
  logic [11:0] m0_araddr, m1_araddr, s_araddr;
  logic [2:0]  m0_arprot, m1_arprot, s_arprot;
  logic        m0_arvalid, m1_arvalid, s_arvalid;
  logic        m0_arready, m1_arready, s_arready;
  logic [31:0] m0_rdata, m1_rdata, s_rdata;
  logic [1:0]  m0_rresp, m1_rresp, s_rresp;
  logic        m0_rvalid, m1_rvalid, s_rvalid;
  logic        m0_rready, m1_rready, s_rready;
  logic [1:0]  grant;
  logic        busy;

  always #5 aclk = ~aclk;

  axil_arbiter_2to1 #(.ADDR_W(12), .DATA_W(32)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .m0_awaddr(m0_awaddr), .m0_awprot(m0_awprot), .m0_awvalid(m0_awvalid), .m0_awready(m0_awready),
    .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_wvalid(m0_wvalid), .m0_wready(m0_wready),
    .m0_bresp(m0_bresp), .m0_bvalid(m0_bvalid), .m0_bready(m0_bready),
    .m0_araddr(m0_araddr), .m0_arprot(m0_arprot), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
    .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
    .m1_awaddr(m1_awaddr), .m1_awprot(m1_awprot), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
    .m1_bresp(m1_bresp), .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
    .m1_araddr(m1_araddr), .m1_arprot(m1_arprot), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
    .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
    .s_awaddr(s_awaddr), .s_awprot(s_awprot), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arprot(s_arprot), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .grant(grant), .busy(busy)
  );

  wire [9:0] m_hs = {m0_awready, m0_wready, m0_bvalid, m0_arready, m0_rvalid,
                     m1_awready, m1_wready, m1_bvalid, m1_arready, m1_rvalid};
  wire [4:0] s_hs = {s_awvalid, s_wvalid, s_arvalid, s_bready, s_rready};

  int n_cmp = 0;
  int n_err = 0;

  // Handshake monitor; done_log holds {owner, is_write} per completed transaction.
  int         aw_beats = 0;
  int         w_beats  = 0;
  logic [1:0] done_log[$];
  always @(posedge aclk) begin
    if (aresetn) begin
      if (s_awvalid && s_awready) aw_beats++;
      if (s_wvalid && s_wready)   w_beats++;
      if (s_bvalid && s_bready)   done_log.push_back({grant[1], 1'b1});
      if (s_rvalid && s_rready)   done_log.push_back({grant[1], 1'b0});
    end
  end

  typedef struct {
    logic        mst;
    logic        wr;
    logic [11:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  sresp;
    logic [1:0]  exp_grant;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mpick(input logic mst, input logic [31:0] a0, input logic [31:0] a1);
    return mst ? a1 : a0;
  endfunction

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic samp();
    @(negedge aclk);
  endtask

  task automatic set_aw(input logic mst, input logic v, input logic [11:0] a,
                        input logic [31:0] d, input logic [3:0] s);
    if (mst) begin
      m1_awvalid = v; m1_wvalid = v; m1_awaddr = a; m1_wdata = d; m1_wstrb = s; m1_awprot = 3'b001;
    end else begin
      m0_awvalid = v; m0_wvalid = v; m0_awaddr = a; m0_wdata = d; m0_wstrb = s; m0_awprot = 3'b010;
    end
  endtask

  task automatic set_ar(input logic mst, input logic v, input logic [11:0] a);
    if (mst) begin
      m1_arvalid = v; m1_araddr = a; m1_arprot = 3'b001;
    end else begin
      m0_arvalid = v; m0_araddr = a; m0_arprot = 3'b010;
    end
  endtask

  task automatic init_inputs();
    set_aw(1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
    set_aw(1'b1, 1'b0, 12'h0, 32'h0, 4'h0);
    set_ar(1'b0, 1'b0, 12'h0);
    set_ar(1'b1, 1'b0, 12'h0);
    m0_bready = 1'b1; m1_bready = 1'b1; m0_rready = 1'b1; m1_rready = 1'b1;
    s_awready = 1'b1; s_wready = 1'b1; s_arready = 1'b1;
    s_bvalid = 1'b0; s_bresp = OKAY; s_rvalid = 1'b0; s_rresp = OKAY; s_rdata = 32'h0;
  endtask

  // One isolated transaction, starting just after a clock edge with the arbiter idle.
  task automatic run_vec(input vec_t v);
    if (v.wr) set_aw(v.mst, 1'b1, v.addr, v.data, v.strb);
    else      set_ar(v.mst, 1'b1, v.addr);
    samp();
    check("idle_grant", 32'(grant), 32'h0);
    check("idle_no_fwd", 32'(s_hs), 32'h0);
    tick(); samp();
    check("grant", 32'(grant), 32'(v.exp_grant));
    check("busy", 32'(busy), 32'h1);
    if (v.wr) begin
      check("s_awvalid", 32'(s_awvalid), 32'h1);
      check("s_awaddr", 32'(s_awaddr), 32'(v.addr));
      check("s_awprot", 32'(s_awprot), v.mst ? 32'h1 : 32'h2);
      check("s_wdata", s_wdata, v.data);
      check("s_wstrb", 32'(s_wstrb), 32'(v.strb));
      check("m_awready", mpick(v.mst, 32'(m0_awready), 32'(m1_awready)), 32'h1);
      check("other_awready", mpick(~v.mst, 32'(m0_awready), 32'(m1_awready)), 32'h0);
    end else begin
      check("s_arvalid", 32'(s_arvalid), 32'h1);
      check("s_araddr", 32'(s_araddr), 32'(v.addr));
      check("s_arprot", 32'(s_arprot), v.mst ? 32'h1 : 32'h2);
      check("m_arready", mpick(v.mst, 32'(m0_arready), 32'(m1_arready)), 32'h1);
    end
    tick();
    set_aw(v.mst, 1'b0, 12'h0, 32'h0, 4'h0);
    set_ar(v.mst, 1'b0, 12'h0);
    if (v.wr) begin
      s_bvalid = 1'b1; s_bresp = v.sresp;
    end else begin
      s_rvalid = 1'b1; s_rresp = v.sresp; s_rdata = v.data;
    end
    samp();
    if (v.wr) begin
      check("m_bvalid", mpick(v.mst, 32'(m0_bvalid), 32'(m1_bvalid)), 32'h1);
      check("m_bresp", mpick(v.mst, 32'(m0_bresp), 32'(m1_bresp)), 32'(v.exp_resp));
      check("other_bvalid", mpick(~v.mst, 32'(m0_bvalid), 32'(m1_bvalid)), 32'h0);
    end else begin
      check("m_rvalid", mpick(v.mst, 32'(m0_rvalid), 32'(m1_rvalid)), 32'h1);
      check("m_rdata", mpick(v.mst, m0_rdata, m1_rdata), v.exp_rdata);
      check("m_rresp", mpick(v.mst, 32'(m0_rresp), 32'(m1_rresp)), 32'(v.exp_resp));
      check("other_rdata", mpick(~v.mst, m0_rdata, m1_rdata), 32'h0);
      check("other_rvalid", mpick(~v.mst, 32'(m0_rvalid), 32'(m1_rvalid)), 32'h0);
    end
    tick();
    s_bvalid = 1'b0; s_rvalid = 1'b0;
    samp();
    check("end_grant", 32'(grant), 32'h0);
    check("end_busy", 32'(busy), 32'h0);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int         base;
    int         aw0, w0, m1_left;
    logic       aw_hs, ar_hs, b_hs, r_hs, m0aw, m0ar, m1ar;
    logic [11:0] ar_cap;
    logic [1:0] exp_order[4];

    vecs[0] = '{1'b0, 1'b1, 12'h008, 32'h1234_5678, 4'hF, OKAY,   2'b01, 2'b00, 32'h0};
    vecs[1] = '{1'b0, 1'b0, 12'h00C, 32'hA5A5_0001, 4'h0, SLVERR, 2'b01, 2'b10, 32'hA5A5_0001};
    vecs[2] = '{1'b1, 1'b1, 12'h010, 32'hCAFE_F00D, 4'h3, DECERR, 2'b10, 2'b11, 32'h0};
    vecs[3] = '{1'b1, 1'b0, 12'h004, 32'hDEAD_BEEF, 4'h0, OKAY,   2'b10, 2'b00, 32'hDEAD_BEEF};
    exp_order[0] = 2'b01;
    exp_order[1] = 2'b10;
    exp_order[2] = 2'b00;
    exp_order[3] = 2'b10;

    // Reset with both masters already requesting reads.
    aresetn = 1'b0;
    init_inputs();
    set_ar(1'b0, 1'b1, 12'h000);
    set_ar(1'b1, 1'b1, 12'h004);
    tick(); tick(); samp();
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_m_hs", 32'(m_hs), 32'h0);
    check("rst_s_hs", 32'(s_hs), 32'h0);
    tick();
    aresetn = 1'b1;
    samp();
    check("rx_arb_cycle_grant", 32'(grant), 32'h0);
    tick(); samp();
    check("rx_grant0", 32'(grant), 32'h1);
    check("rx_s_araddr0", 32'(s_araddr), 32'h000);
    check("rx_m1_arready", 32'(m1_arready), 32'h0);
    tick();
    m0_arvalid = 1'b0; s_rvalid = 1'b1; s_rdata = 32'h1111_0000;
    samp();
    check("rx_m0_rdata", m0_rdata, 32'h1111_0000);
    check("rx_m1_rdata0", m1_rdata, 32'h0);
    check("rx_m1_rvalid0", 32'(m1_rvalid), 32'h0);
    tick();
    s_rvalid = 1'b0;
    samp();
    check("rx_idle_grant", 32'(grant), 32'h0);
    tick(); samp();
    check("rx_grant1", 32'(grant), 32'h2);
    check("rx_s_araddr1", 32'(s_araddr), 32'h004);
    tick();
    m1_arvalid = 1'b0; s_rvalid = 1'b1; s_rdata = 32'h2222_0000;
    samp();
    check("rx_m1_rdata", m1_rdata, 32'h2222_0000);
    check("rx_m0_rdata1", m0_rdata, 32'h0);
    check("rx_m0_rvalid1", 32'(m0_rvalid), 32'h0);
    tick();
    s_rvalid = 1'b0;
    samp();
    check("rx_end_grant", 32'(grant), 32'h0);

    // M0 asks for a write and a read at once while M1 streams two reads.
    tick();
    base = done_log.size();
    set_aw(1'b0, 1'b1, 12'h040, 32'h0BAD_F00D, 4'hF);
    set_ar(1'b0, 1'b1, 12'h044);
    set_ar(1'b1, 1'b1, 12'h048);
    m1_left = 2;
    for (int cyc = 0; cyc < 60 && done_log.size() < base + 4; cyc++) begin
      samp();
      aw_hs  = s_awvalid & s_awready;
      ar_hs  = s_arvalid & s_arready;
      b_hs   = s_bvalid & s_bready;
      r_hs   = s_rvalid & s_rready;
      m0aw   = m0_awvalid & m0_awready;
      m0ar   = m0_arvalid & m0_arready;
      m1ar   = m1_arvalid & m1_arready;
      ar_cap = s_araddr;
      tick();
      if (b_hs) s_bvalid = 1'b0;
      if (r_hs) s_rvalid = 1'b0;
      if (aw_hs) begin s_bvalid = 1'b1; s_bresp = OKAY; end
      if (ar_hs) begin s_rvalid = 1'b1; s_rdata = 32'(ar_cap); end
      if (m0aw) begin m0_awvalid = 1'b0; m0_wvalid = 1'b0; end
      if (m0ar) m0_arvalid = 1'b0;
      if (m1ar) begin
        m1_left--;
        if (m1_left == 0) m1_arvalid = 1'b0;
        else m1_araddr = 12'h04C;
      end
    end
    check("rr_txn_count", 32'(done_log.size() - base), 32'h4);
    for (int i = 0; i < 4; i++)
      if (done_log.size() > base + i)
        check($sformatf("rr_order[%0d]", i), 32'(done_log[base + i]), 32'(exp_order[i]));

    // W accepted two cycles before AW; M0 keeps its next W beat pending.
    s_awready = 1'b0; s_wready = 1'b1;
    aw0 = aw_beats; w0 = w_beats;
    set_aw(1'b0, 1'b1, 12'h020, 32'h0000_BEEF, 4'hC);
    samp();
    tick(); samp();
    check("split_s_wvalid", 32'(s_wvalid), 32'h1);
    check("split_m0_wready", 32'(m0_wready), 32'h1);
    check("split_m0_awready0", 32'(m0_awready), 32'h0);
    tick(); samp();
    check("split_wvalid_drop", 32'(s_wvalid), 32'h0);
    check("split_wready_drop", 32'(m0_wready), 32'h0);
    check("split_awvalid_held", 32'(s_awvalid), 32'h1);
    check("split_no_bready", 32'(s_bready), 32'h0);
    tick();
    s_awready = 1'b1;
    samp();
    check("split_wvalid_still0", 32'(s_wvalid), 32'h0);
    check("split_m0_awready", 32'(m0_awready), 32'h1);
    check("split_no_bready2", 32'(s_bready), 32'h0);
    tick();
    set_aw(1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
    s_bvalid = 1'b1; s_bresp = OKAY;
    samp();
    check("split_m0_bvalid", 32'(m0_bvalid), 32'h1);
    check("split_aw_beats", 32'(aw_beats - aw0), 32'h1);
    check("split_w_beats", 32'(w_beats - w0), 32'h1);
    tick();
    s_bvalid = 1'b0;
    samp();
    check("split_end_busy", 32'(busy), 32'h0);
    tick();

    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    // Reset while a read response is held with rready low.
    set_ar(1'b0, 1'b1, 12'h030);
    set_aw(1'b1, 1'b1, 12'h034, 32'h5555_AAAA, 4'hF);
    m0_rready = 1'b0;
    samp();
    tick(); samp();
    check("mr_grant", 32'(grant), 32'h1);
    tick();
    m0_arvalid = 1'b0; s_rvalid = 1'b1; s_rdata = 32'h7777_0000;
    samp();
    check("mr_m0_rvalid", 32'(m0_rvalid), 32'h1);
    check("mr_busy", 32'(busy), 32'h1);
    tick();
    aresetn = 1'b0;
    samp();
    tick(); samp();
    check("mr_rst_grant", 32'(grant), 32'h0);
    check("mr_rst_busy", 32'(busy), 32'h0);
    check("mr_rst_m_hs", 32'(m_hs), 32'h0);
    check("mr_rst_s_hs", 32'(s_hs), 32'h0);
    tick();
    aresetn = 1'b1;
    init_inputs();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axil_arbiter_2to1.md
# axil_arbiter_2to1

Two-master to one-slave AXI4-Lite arbiter that shares a single peripheral port, such as the timer peripheral, between the CPU load/store unit (M0) and a secondary master (M1, DMA/debug). It grants the slave for one complete transaction at a time, using round-robin fairness between masters and write-over-read priority within a master. While a transaction is granted, the granted master's channels are forwarded combinationally to the slave.

## Interface
- ADDR_W, 12, address width on all ports
- DATA_W, 32, data width; strobe width is DATA_W/8
- aclk  in  1  clock
- aresetn  in  1  reset, synchronous, active-low
- m0_awaddr/awprot/awvalid/awready, m0_wdata/wstrb/wvalid/wready, m0_bresp/bvalid/bready, m0_araddr/arprot/arvalid/arready, m0_rdata/rresp/rvalid/rready
  - slave-side AXI4-Lite port for master 0
  - widths: ADDR_W, 3, 1, DATA_W, DATA_W/8, 2
- m1_* : same set as m0_*, for master 1
- s_* : same set, mirrored direction; master-side AXI4-Lite port to the peripheral
- grant  out  2  one-hot owner of the slave; 0 when idle
- busy  out  1  transaction in flight

## Operation
- States:
  - IDLE
  - WR: AW and/or W still pending
  - WR_RESP
  - RD_ADDR
  - RD_RESP
- Request of master i: req_i = mi_awvalid | mi_arvalid.
- In IDLE, pick a master:
  - Only one master requesting: it wins.
  - Both requesting: the master not equal to last_owner wins.
  - Winner with awvalid goes to WR; otherwise it goes to RD_ADDR.
  - Register grant, direction and last_owner <= winner.
  - No channel is forwarded during IDLE.
- WR:
  - Forward the owner's AW and W to the slave, and the slave's awready/wready back to the owner.
  - Sticky flags aw_done and w_done set on each handshake; a channel whose flag is set has its forwarded valid forced to 0.
  - Both handshakes complete (same or different cycles): clear the flags and go to WR_RESP.
- WR_RESP: forward B in both directions; on bvalid & bready go to IDLE and clear grant.
- RD_ADDR: forward AR; on arvalid & arready go to RD_RESP.
- RD_RESP: forward R; on rvalid & rready go to IDLE and clear grant.
- Non-owner master:
  - all ready and valid outputs are 0;
  - its valids stay pending, as AXI requires, and are served later.
- Data and response payloads (bresp, rresp, rdata) pass through unmodified. Non-owner payload outputs are driven to 0.
- Reset:
  - state IDLE, grant 0, busy 0, last_owner = M1, so M0 wins the first tie;
  - every ready/valid output 0 from the first cycle after reset;
  - aw_done/w_done cleared.
- Reset mid-transaction abandons it. No response is generated; masters and slave are reset together.

## Timing
- Arbitration costs exactly one cycle. A request seen in IDLE at cycle N is forwarded on s_* at cycle N+1.
- After a B or R handshake at cycle N, the arbiter is in IDLE at N+1; a new grant is forwarded at N+2.
- All forwarding is combinational, with no extra latency. Handshake ready/valid outputs depend combinationally on inputs only through the registered grant/state, plus the sticky-flag gating of the forwarded AW/W valids.
- A master asserting awvalid and arvalid together gets the write first and the read in a later arbitration round. That round is not guaranteed to be the next one if the other master is waiting.
- Back-to-back requests from both masters alternate strictly M0, M1, M0, …

## Structure
- Shared package (`axil_pkg`):
  - arbiter state enum (IDLE, WR, WR_RESP, RD_ADDR, RD_RESP);
  - AXI response constants OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11.
- Sub-module `axil_rr_pick`: combinational two-way round-robin selector with inputs req[1:0] and last_owner, outputs winner and valid.
- Mux/demux and FSM stay in the top module.

## Test plan
- Single M0 write awaddr 0x008, wdata 0x1234_5678, wstrb 0xF -> s_awaddr 0x008 one cycle after request; grant = 01; m0_bvalid with OKAY; idle afterwards.
- M0 and M1 reads both asserted at reset exit (0x000 and 0x004) -> M0 served first, then M1; rdata routed only to the correct master; grant sequence 01, 00, 10.
- Slave accepts W two cycles before AW -> s_wvalid drops after the W handshake; exactly one W beat and one AW beat seen; WR_RESP only after both.
- Slave returns bresp 2'b11 for address 0x010 -> M1 receives bresp 2'b11 unmodified.
- M0 holds awvalid and arvalid together while M1 streams reads -> order M0 write, M1 read, M0 read, M1 read; no master starved.
- aresetn low during RD_RESP with rvalid held -> next cycle: grant 0, busy 0, all m*_ ready/valid 0.
